enveloped_square_osc: RTL and testbench
=======================================

// Module: enveloped_square_osc
// PURPOSE
//   Gated square-wave tone generator with a linear attack/release amplitude envelope.
//   Replaces hard on/off tones: the amplitude ramps up and down, so tone starts and
//   stops are click-free. The period can be retuned glitch-free.
//   Sits between game/tone-select logic (gate, half_wav) and the audio codec sample path (out).
// PARAMETERS
//   WIDTH      32          output sample width, signed two's complement
//   CNT_W      20          half-period counter width
//   AMPLITUDE  10_000_000  sustain envelope level; must be < 2^(WIDTH-1)
//   RAMP_STEP  10_000      envelope increment/decrement per ramp tick (>0)
//   RAMP_DIV   500         clocks per ramp tick (>=1)
// PORTS
//   CLOCK_50  in   1      system clock; all logic rising-edge
//   reset_n   in   1      asynchronous, active-low reset
//   gate      in   1      1 = tone on (attack/sustain), 0 = tone off (release)
//   half_wav  in   CNT_W  half-period minus one, in clocks
//   out       out  WIDTH  signed sample: +env when phase=1, -env when phase=0, 0 in IDLE
//   active    out  1      1 whenever state != IDLE
//   edge      out  1      one-cycle pulse on every phase toggle
// BEHAVIOUR
//   Reset (reset_n=0, async): state=IDLE; env, count, phase, hw_lat, prescaler=0;
//     out=0, active=0, edge=0. Reset mid-tone aborts immediately; no ramp-down.
//   State machine (registered), gate sampled each rising edge:
//     IDLE    : gate=1 -> ATTACK; same edge: count=0, phase=0, prescaler=0, hw_lat=half_wav.
//     ATTACK  : on tick, env=min(env+RAMP_STEP, AMPLITUDE); reaching AMPLITUDE -> SUSTAIN.
//               gate=0 -> RELEASE; takes priority over the SUSTAIN transition on the same edge.
//     SUSTAIN : env held at AMPLITUDE; gate=0 -> RELEASE.
//     RELEASE : on tick, env=max(env-RAMP_STEP, 0); env reaching 0 -> IDLE.
//               gate=1 -> ATTACK; env continues from its current value.
//               Phase, count and prescaler are not reset.
//   Ramp tick: prescaler counts 0..RAMP_DIV-1 and wraps; tick=1 when prescaler==RAMP_DIV-1.
//     The prescaler free-runs in all non-IDLE states. It is held at 0 in IDLE.
//   Envelope math: env is an unsigned WIDTH-1 bit register. The saturation compare is
//     done at WIDTH bits, so there is no overflow or underflow wrap.
//   Oscillator: active in all non-IDLE states.
//     When count==hw_lat: count=0, phase toggles, edge=1 the next cycle, hw_lat=half_wav.
//     Otherwise count+1.
//     Each half-period lasts hw_lat+1 clocks. half_wav=0 toggles phase every clock.
//   Retune: half_wav is sampled only at half-period boundaries (and on IDLE->ATTACK).
//     Mid-half-period changes never shorten or extend the current half-period.
//   Output: out <= (state==IDLE) ? 0 : (phase ? env : -env), registered.
//     out lags env/phase by 1 clock. The first nonzero out appears 2 clocks after the
//     first tick. active is registered from the next state. edge is registered.
//   Entering IDLE from RELEASE forces out=0, phase=0 and count=0 on the following edge.
// TESTING (bench params: AMPLITUDE=100, RAMP_STEP=30, RAMP_DIV=4, WIDTH=32, CNT_W=20)
//   1 Attack: reset, gate=1, half_wav=9
//       -> env 30,60,90,100 on ticks 1-4 (every 4 clocks); |out| follows 1 clk later;
//          SUSTAIN after tick 4; active=1 from the gate edge.
//   2 Period: SUSTAIN, half_wav=9
//       -> edge every 10 clocks; out alternates +100/-100; full period 20 clocks.
//   3 Retune: half_wav 9->4 applied 3 clocks into a half-period
//       -> that half-period still lasts 10 clocks; subsequent half-periods last 5.
//   4 Release/retrigger: gate=0 in SUSTAIN
//       -> env 70,40,10,0 then IDLE, out=0, active=0.
//       Repeat, re-raising gate at env=40 -> env 70,100, no phase/count reset.
//   5 Async reset: pull reset_n low between clock edges in SUSTAIN
//       -> out=0, active=0, edge=0 before the next edge; after release, IDLE until gate=1.
//   6 Boundary: half_wav=0 -> phase toggles every clock; gate pulse of 1 clock
//       -> ATTACK then RELEASE from env 0/30, returning to IDLE, out ends 0.

Source files
------------

// File: rtl/enveloped_square_osc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : enveloped_square_osc                                            |
// | Purpose  : Gated square-wave tone with linear attack/release envelope.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module enveloped_square_osc #(
    parameter int WIDTH     = 32,
    parameter int CNT_W     = 20,
    parameter int AMPLITUDE = 10_000_000,
    parameter int RAMP_STEP = 10_000,
    parameter int RAMP_DIV  = 500
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    input  logic                    gate,
    input  logic [CNT_W-1:0]        half_wav,
    output logic signed [WIDTH-1:0] out,
    output logic                    active,
    output logic                    phase_edge
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ATTACK  = 2'd1,
        S_SUSTAIN = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam int PS_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [WIDTH-1:0] c_amp     = WIDTH'(AMPLITUDE);
    localparam logic [WIDTH-1:0] c_step    = WIDTH'(RAMP_STEP);
    localparam logic [PS_W-1:0]  c_ps_last = PS_W'(RAMP_DIV - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-2:0]   r_env;
    logic [WIDTH-2:0]   w_env_next;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_hw_lat;
    logic               r_phase;
    logic [PS_W-1:0]    r_prescaler;
    logic               w_tick;
    logic               w_wrap;
    logic [WIDTH-1:0]   w_env_wide;
    logic [WIDTH-1:0]   w_env_sum;
    logic [WIDTH-1:0]   w_env_up;
    logic [WIDTH-1:0]   w_env_down;

    // Ramp arithmetic is one bit wider than env so saturation never wraps.
    always_comb begin
        w_tick     = (r_state != S_IDLE) && (r_prescaler == c_ps_last);
        w_wrap     = (r_count == r_hw_lat);
        w_env_wide = {1'b0, r_env};
        w_env_sum  = w_env_wide + c_step;
        w_env_up   = (w_env_sum >= c_amp) ? c_amp : w_env_sum;
        w_env_down = (w_env_wide <= c_step) ? '0 : (w_env_wide - c_step);

        w_env_next = r_env;
        case (r_state)
            S_ATTACK:  if (w_tick) w_env_next = w_env_up[WIDTH-2:0];
            S_RELEASE: if (w_tick) w_env_next = w_env_down[WIDTH-2:0];
            default:   w_env_next = r_env;
        endcase

        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (gate) w_state_next = S_ATTACK;
            end
            S_ATTACK: begin
                if (!gate)
                    w_state_next = S_RELEASE;
                else if (w_tick && (w_env_up == c_amp))
                    w_state_next = S_SUSTAIN;
            end
            S_SUSTAIN: begin
                if (!gate) w_state_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (gate)
                    w_state_next = S_ATTACK;
                else if (w_tick && (w_env_down == '0))
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_env       <= '0;
            r_count     <= '0;
            r_hw_lat    <= '0;
            r_phase     <= 1'b0;
            r_prescaler <= '0;
            out         <= '0;
            active      <= 1'b0;
            phase_edge  <= 1'b0;
        end else begin
            r_env  <= w_env_next;
            out    <= (r_state == S_IDLE) ? '0 : (r_phase ? w_env_wide : -w_env_wide);
            active <= (w_state_next != S_IDLE);
            if (r_state == S_IDLE) begin
                // Idle parks the oscillator so every tone starts at phase 0.
                r_count     <= '0;
                r_phase     <= 1'b0;
                r_prescaler <= '0;
                phase_edge  <= 1'b0;
                if (gate) r_hw_lat <= half_wav;
            end else begin
                r_prescaler <= w_tick ? '0 : (r_prescaler + 1'b1);
                if (w_wrap) begin
                    r_count    <= '0;
                    r_phase    <= ~r_phase;
                    phase_edge <= 1'b1;
                    r_hw_lat   <= half_wav;
                end else begin
                    r_count    <= r_count + 1'b1;
                    phase_edge <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_enveloped_square_osc.sv
`default_nettype none
// Testbench for enveloped_square_osc: directed scenarios plus random gating,
// each cycle checked against a behavioural envelope/oscillator model.
module tb_enveloped_square_osc;

    localparam int W    = 32;
    localparam int CW   = 20;
    localparam int AMP  = 100;
    localparam int STEP = 30;
    localparam int RDIV = 4;

    logic                 clk;
    logic                 reset_n;
    logic                 gate;
    logic [CW-1:0]        half_wav;
    logic signed [W-1:0]  out;
    logic                 active;
    logic                 phase_edge;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    string m_mode;
    int    m_env;
    int    m_phase;
    int    m_age;
    int    m_left;
    int    m_out;
    logic  m_edge;
    logic  m_active;

    enveloped_square_osc #(
        .WIDTH    (W),
        .CNT_W    (CW),
        .AMPLITUDE(AMP),
        .RAMP_STEP(STEP),
        .RAMP_DIV (RDIV)
    ) dut (
        .CLOCK_50  (clk),
        .reset_n   (reset_n),
        .gate      (gate),
        .half_wav  (half_wav),
        .out       (out),
        .active    (active),
        .phase_edge(phase_edge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_mode = "idle"; m_env = 0; m_phase = 0; m_age = 0; m_left = 0;
        m_out = 0; m_edge = 1'b0; m_active = 1'b0;
    endtask

    // One rising edge of the behavioural model, given the inputs sampled there.
    task automatic model_edge(input logic g, input int hw);
        bit tick;
        m_out = (m_mode == "idle") ? 0 : (m_phase != 0 ? m_env : -m_env);
        if (m_mode == "idle") begin
            m_phase = 0; m_age = 0; m_edge = 1'b0;
            if (g) begin
                m_mode = "attack";
                m_left = hw + 1;
            end
        end else begin
            tick  = (m_age % RDIV) == (RDIV - 1);
            m_age = m_age + 1;
            if (m_mode == "attack" && tick)  m_env = (m_env + STEP > AMP) ? AMP : m_env + STEP;
            if (m_mode == "release" && tick) m_env = (m_env - STEP < 0) ? 0 : m_env - STEP;
            if (m_mode == "attack") begin
                if (!g) m_mode = "release";
                else if (tick && m_env == AMP) m_mode = "sustain";
            end else if (m_mode == "sustain") begin
                if (!g) m_mode = "release";
            end else if (m_mode == "release") begin
                if (g) m_mode = "attack";
                else if (tick && m_env == 0) m_mode = "idle";
            end
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_phase = 1 - m_phase;
                m_edge  = 1'b1;
                m_left  = hw + 1;
            end else begin
                m_edge = 1'b0;
            end
        end
        m_active = (m_mode != "idle");
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(gate, int'(half_wav));
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; gate = 1'b0; half_wav = 20'd9;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if (out !== 0 || active !== 1'b0 || phase_edge !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state out=%0d active=%b edge=%b expected 0/0/0", out, active, phase_edge);
        end
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (out !== m_out || active !== 1'b0 || phase_edge !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d out=%0d active=%b edge=%b expected 0/0/0", c, out, active, phase_edge);
            end
        end
    endtask

    task automatic test_attack();
        int exp_abs[4] = '{30, 60, 90, 100};
        int k;
        gate = 1'b1; half_wav = 20'd9;
        for (int c = 0; c < 18; c++) begin
            step();
            n_checks++;
            if (out !== m_out || active !== m_active || phase_edge !== m_edge) begin
                n_fail++;
                $display("FAIL attack_model c=%0d out=%0d exp=%0d active=%b exp=%b edge=%b exp=%b",
                         c, out, m_out, active, m_active, phase_edge, m_edge);
            end
            if (c == 0) begin
                n_checks++;
                if (active !== 1'b1) begin
                    n_fail++;
                    $display("FAIL attack_active_at_gate active=%b expected 1", active);
                end
            end
            if (c >= 5 && ((c - 5) % 4) == 0) begin
                k = (c - 5) / 4;
                n_checks++;
                if (iabs(int'(out)) != exp_abs[k]) begin
                    n_fail++;
                    $display("FAIL attack_env_tick%0d |out|=%0d expected %0d", k + 1, iabs(int'(out)), exp_abs[k]);
                end
            end
        end
    endtask

    task automatic test_period();
        int cyc = 0, last = -1, seen = 0;
        while (seen < 5 && cyc < 100) begin
            step();
            cyc++;
            n_checks++;
            if (out !== m_out || active !== m_active || phase_edge !== m_edge) begin
                n_fail++;
                $display("FAIL period_model cyc=%0d out=%0d exp=%0d active=%b exp=%b edge=%b exp=%b",
                         cyc, out, m_out, active, m_active, phase_edge, m_edge);
            end
            n_checks++;
            if (iabs(int'(out)) != AMP) begin
                n_fail++;
                $display("FAIL period_amplitude |out|=%0d expected %0d", iabs(int'(out)), AMP);
            end
            if (phase_edge === 1'b1) begin
                if (last >= 0) begin
                    n_checks++;
                    if (cyc - last != 10) begin
                        n_fail++;
                        $display("FAIL period_half got=%0d clocks expected 10", cyc - last);
                    end
                end
                last = cyc;
                seen++;
            end
        end
        if (seen < 5) begin
            n_checks++; n_fail++;
            $display("FAIL period_timeout edges=%0d expected 5", seen);
        end
    endtask

    task automatic test_retune();
        int cyc = 0, last = -1, seen = 0;
        int exp_len[3] = '{10, 5, 5};
        while (last < 0 && cyc < 30) begin
            step(); cyc++;
            if (phase_edge === 1'b1) last = cyc;
        end
        if (last < 0) begin
            n_checks++; n_fail++;
            $display("FAIL retune_sync no edge within %0d clocks", cyc);
        end else begin
            repeat (3) begin
                step(); cyc++;
                n_checks++;
                if (out !== m_out || phase_edge !== m_edge) begin
                    n_fail++;
                    $display("FAIL retune_model out=%0d exp=%0d edge=%b exp=%b", out, m_out, phase_edge, m_edge);
                end
            end
            half_wav = 20'd4;
            while (seen < 3 && cyc < last + 60) begin
                step(); cyc++;
                n_checks++;
                if (out !== m_out || active !== m_active || phase_edge !== m_edge) begin
                    n_fail++;
                    $display("FAIL retune_model out=%0d exp=%0d active=%b exp=%b edge=%b exp=%b",
                             out, m_out, active, m_active, phase_edge, m_edge);
                end
                if (phase_edge === 1'b1) begin
                    n_checks++;
                    if (cyc - last != exp_len[seen]) begin
                        n_fail++;
                        $display("FAIL retune_half%0d got=%0d clocks expected %0d", seen, cyc - last, exp_len[seen]);
                    end
                    last = cyc;
                    seen++;
                end
            end
            if (seen < 3) begin
                n_checks++; n_fail++;
                $display("FAIL retune_timeout edges=%0d expected 3", seen);
            end
        end
    endtask

    task automatic test_release_retrigger();
        int seq[$];
        int prev, a, cyc;
        int exp_rel[3] = '{70, 40, 10};
        int exp_re[2]  = '{70, 100};
        // Release from sustain down to idle.
        gate = 1'b0; prev = iabs(int'(out)); cyc = 0;
        while (active === 1'b1 && cyc < 40) begin
            step(); cyc++;
            n_checks++;
            if (out !== m_out || active !== m_active || phase_edge !== m_edge) begin
                n_fail++;
                $display("FAIL release_model out=%0d exp=%0d active=%b exp=%b edge=%b exp=%b",
                         out, m_out, active, m_active, phase_edge, m_edge);
            end
            a = iabs(int'(out));
            if (a != prev) begin seq.push_back(a); prev = a; end
        end
        n_checks++;
        if (seq.size() != 3) begin
            n_fail++;
            $display("FAIL release_steps got=%0d levels expected 3", seq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (seq[i] != exp_rel[i]) begin
                    n_fail++;
                    $display("FAIL release_level%0d got=%0d expected %0d", i, seq[i], exp_rel[i]);
                end
            end
        end
        step();
        n_checks++;
        if (out !== 0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL release_idle out=%0d active=%b expected 0/0", out, active);
        end
        // Back to sustain, then release and retrigger at env 40.
        gate = 1'b1; cyc = 0;
        while (iabs(int'(out)) != AMP && cyc < 40) begin step(); cyc++; end
        gate = 1'b0; cyc = 0;
        while (iabs(int'(out)) != 40 && cyc < 40) begin
            step(); cyc++;
            n_checks++;
            if (out !== m_out || active !== m_active || phase_edge !== m_edge) begin
                n_fail++;
                $display("FAIL retrig_model out=%0d exp=%0d active=%b exp=%b edge=%b exp=%b",
                         out, m_out, active, m_active, phase_edge, m_edge);
            end
        end
        gate = 1'b1; seq.delete(); prev = 40; cyc = 0;
        while (prev != AMP && cyc < 30) begin
            step(); cyc++;
            n_checks++;
            if (out !== m_out || active !== 1'b1 || phase_edge !== m_edge) begin
                n_fail++;
                $display("FAIL retrig_track out=%0d exp=%0d active=%b exp=1 edge=%b exp=%b",
                         out, m_out, active, phase_edge, m_edge);
            end
            a = iabs(int'(out));
            if (a != prev) begin seq.push_back(a); prev = a; end
        end
        n_checks++;
        if (seq.size() != 2 || seq[0] != exp_re[0] || seq[1] != exp_re[1]) begin
            n_fail++;
            $display("FAIL retrig_levels count=%0d first=%0d expected 2 levels 70,100",
                     seq.size(), (seq.size() > 0) ? seq[0] : -1);
        end
    endtask

    task automatic test_async_reset();
        repeat (3) step();
        #3;
        reset_n = 1'b0; gate = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (out !== 0 || active !== 1'b0 || phase_edge !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset out=%0d active=%b edge=%b expected 0/0/0", out, active, phase_edge);
        end
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++;
            if (out !== 0 || active !== 1'b0 || out !== m_out) begin
                n_fail++;
                $display("FAIL async_idle c=%0d out=%0d active=%b expected 0/0", c, out, active);
            end
        end
        gate = 1'b1;
        step();
        n_checks++;
        if (active !== 1'b1 || active !== m_active) begin
            n_fail++;
            $display("FAIL async_restart active=%b expected 1", active);
        end
    endtask

    task automatic test_boundary();
        int cyc;
        reset_n = 1'b0; gate = 1'b0;
        @(posedge clk); #1;
        model_reset();
        reset_n = 1'b1;
        half_wav = 20'd0; gate = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++;
            if (out !== m_out || active !== m_active || phase_edge !== m_edge) begin
                n_fail++;
                $display("FAIL hw0_model c=%0d out=%0d exp=%0d edge=%b exp=%b", c, out, m_out, phase_edge, m_edge);
            end
            if (c >= 1) begin
                n_checks++;
                if (phase_edge !== 1'b1) begin
                    n_fail++;
                    $display("FAIL hw0_toggle c=%0d edge=%b expected 1", c, phase_edge);
                end
            end
        end
        gate = 1'b0; cyc = 0;
        while (active === 1'b1 && cyc < 60) begin step(); cyc++; end
        step();
        // One-clock gate pulse from idle.
        gate = 1'b1;
        step();
        gate = 1'b0;
        cyc = 0;
        do begin
            step(); cyc++;
            n_checks++;
            if (out !== m_out || active !== m_active || phase_edge !== m_edge) begin
                n_fail++;
                $display("FAIL pulse_model cyc=%0d out=%0d exp=%0d active=%b exp=%b edge=%b exp=%b",
                         cyc, out, m_out, active, m_active, phase_edge, m_edge);
            end
        end while (active === 1'b1 && cyc < 20);
        step();
        n_checks++;
        if (out !== 0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_end out=%0d active=%b expected 0/0 after %0d clocks", out, active, cyc);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 39) == 0) gate = ~gate;
            if ($urandom_range(0, 19) == 0) half_wav = CW'($urandom_range(0, 12));
            step();
            n_checks++;
            if (out !== m_out || active !== m_active || phase_edge !== m_edge) begin
                n_fail++;
                $display("FAIL random_model c=%0d out=%0d exp=%0d active=%b exp=%b edge=%b exp=%b",
                         c, out, m_out, active, m_active, phase_edge, m_edge);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; gate = 1'b0; half_wav = '0;
        model_reset();
        test_reset();
        test_attack();
        test_period();
        test_retune();
        test_release_retrigger();
        test_async_reset();
        test_boundary();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
